// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory write model:
// state encoding and the byte order used when packing host bytes into words.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Instruction words are big-endian: the first byte received is the MSB.
    localparam logic BIG_ENDIAN = 1'b1;

    function automatic logic [4:0] lane_shift(input logic [1:0] idx);
        logic [4:0] sh;
        if (BIG_ENDIAN) begin
            sh = {~idx, 3'b000};
        end else begin
            sh = {idx, 3'b000};
        end
        return sh;
    endfunction

    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  data);
        logic [4:0] sh;
        sh = lane_shift(idx);
        return (word & ~(32'h0000_00FF << sh)) | ({24'h00_0000, data} << sh);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted host bytes into a 32-bit instruction word and flags when
// the fourth byte of the word has landed.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic        consume,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte,
    output logic        word_full
);

    logic [1:0]  idx_r;
    logic [31:0] word_r;
    logic        word_full_r;

    // Byte index, word register and full flag; clear restarts a load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r       <= 2'd0;
            word_r      <= 32'h0000_0000;
            word_full_r <= 1'b0;
        end else if (clear) begin
            idx_r       <= 2'd0;
            word_r      <= 32'h0000_0000;
            word_full_r <= 1'b0;
        end else begin
            if (accept) begin
                word_r <= insert_byte(word_r, idx_r, byte_in);
                idx_r  <= idx_r + 2'd1;
            end
            if (accept && (idx_r == 2'd3)) begin
                word_full_r <= 1'b1;
            end else if (consume) begin
                word_full_r <= 1'b0;
            end
        end
    end

    assign word      = word_r;
    assign last_byte = (idx_r == 2'd3);
    assign word_full = word_full_r;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a host byte stream into big-endian words, writes them
// to instruction memory and holds the fetch pipeline until the load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-3:0] word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              pc_hold,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    localparam int                CNT_W    = ADDR_W - 2;
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  remaining_r;
    logic [CNT_W-1:0]  remaining_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic [7:0]        checksum_r;
    logic [7:0]        checksum_next_s;
    logic              in_ready_r;
    logic              mem_we_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_s;
    logic              clear_s;
    logic              consume_s;
    logic              last_byte_s;
    logic              word_full_s;
    logic [31:0]       word_s;

    assign accept_s  = in_valid && in_ready_r && (state_r == RECV);
    assign clear_s   = (state_r == IDLE) && start;
    assign consume_s = (state_r == WRITE);

    byte_assembler u_byte_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .accept    (accept_s),
        .consume   (consume_s),
        .byte_in   (in_data),
        .word      (word_s),
        .last_byte (last_byte_s),
        .word_full (word_full_s)
    );

    // Next-state, remaining count, address and checksum.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        addr_next_s      = addr_r;
        checksum_next_s  = checksum_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    checksum_next_s = 8'h00;
                    addr_next_s     = BASE_ADDR;
                    if (word_count != CNT_ZERO) begin
                        remaining_next_s = word_count;
                        state_next_s     = RECV;
                    end else begin
                        remaining_next_s = CNT_ZERO;
                        state_next_s     = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RECV: begin
                if (accept_s) begin
                    checksum_next_s = checksum_r + in_data;
                    if (last_byte_s) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = RECV;
                    end
                end else begin
                    state_next_s = RECV;
                end
            end
            WRITE: begin
                // A WRITE without a complete word means corrupted state: end the load.
                if (word_full_s) begin
                    remaining_next_s = remaining_r - CNT_ONE;
                    addr_next_s      = addr_r + ADDR_STEP;
                    if (remaining_r != CNT_ONE) begin
                        state_next_s = RECV;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = DONE;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters and the registered output strobes decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            remaining_r <= CNT_ZERO;
            addr_r      <= BASE_ADDR;
            checksum_r  <= 8'h00;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            addr_r      <= addr_next_s;
            checksum_r  <= checksum_next_s;
            in_ready_r  <= (state_next_s == RECV);
            mem_we_r    <= (state_next_s == WRITE);
            busy_r      <= (state_next_s != IDLE);
            done_r      <= (state_next_s == DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = word_s;
    assign pc_hold   = busy_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign checksum  = checksum_r;

endmodule
